// File: rtl/pipe_seq_pkg.sv
// Shared types and defaults for the pipeline sequencer.
package pipe_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    VECTOR = 2'd3
  } seqStateT;

  localparam int DEF_NUM_STAGES = 2;
  localparam int DEF_ADDR_W     = 8;
  localparam int DEF_STALL_W    = 8;

  localparam logic [7:0] DEF_VEC_ADDR = 8'hF0;

endpackage

// File: rtl/irq_capture.sv
// Interrupt capture: rising-edge detect on irq plus a pending latch.
// Clear has priority over a coincident set so a stop or vector entry
// always leaves nothing pending.
module irq_capture (
  input  logic clk,
  input  logic rst_n,
  input  logic irq,
  input  logic enable,
  input  logic clear,
  output logic pending
);

  logic irqPrev;

  // Track the previous irq sample and latch edges seen while enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irqPrev <= 1'b0;
      pending <= 1'b0;
    end else begin
      irqPrev <= irq;
      if (clear) begin
        pending <= 1'b0;
      end else if (enable && irq && !irqPrev) begin
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipe_sequencer.sv
// Pipeline sequencer: advance handshake across NUM_STAGES stages,
// start/stop control, interrupt drain/flush/vector and stall accounting.
// Optional feature macro: PIPE_SEQ_STALL_CNT_EN (stall counter present when defined,
// otherwise stall_cnt is tied to zero).
module pipe_sequencer
  import pipe_seq_pkg::*;
#(
  parameter int                NUM_STAGES = DEF_NUM_STAGES,
  parameter int                ADDR_W     = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] VEC_ADDR   = ADDR_W'(DEF_VEC_ADDR),
  parameter int                STALL_W    = DEF_STALL_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [NUM_STAGES-1:0] stage_done,
  input  logic [ADDR_W-1:0]     pc_next,
  input  logic                  irq,
  input  logic                  iret,
  output logic                  advance,
  output logic                  flush,
  output logic                  redirect_valid,
  output logic [ADDR_W-1:0]     redirect_addr,
  output logic [ADDR_W-1:0]     epc,
  output logic                  running,
  output logic                  in_isr,
  output logic [STALL_W-1:0]    stall_cnt
);

  seqStateT          state, stateNext;
  logic              allDone;
  logic              irqPending;
  logic              pendingClear;
  logic              advanceNext, flushNext, redirectValidNext, inIsrNext;
  logic [ADDR_W-1:0] redirectAddrNext, epcNext;

  assign allDone = &stage_done;

  irq_capture uIrqCapture (
    .clk     (clk),
    .rst_n   (rst_n),
    .irq     (irq),
    .enable  (state != IDLE),
    .clear   (pendingClear),
    .pending (irqPending)
  );

  // Next-state and next-output decode; stop overrides every other event.
  always_comb begin
    stateNext         = state;
    advanceNext       = 1'b0;
    flushNext         = 1'b0;
    redirectValidNext = 1'b0;
    redirectAddrNext  = redirect_addr;
    epcNext           = epc;
    inIsrNext         = in_isr;
    pendingClear      = 1'b0;
    if (!start) begin
      stateNext    = IDLE;
      inIsrNext    = 1'b0;
      pendingClear = 1'b1;
    end else begin
      if (iret) begin
        inIsrNext = 1'b0;
      end
      case (state)
        IDLE: stateNext = RUN;
        RUN: begin
          // Draining waits out an advance in flight so stages see it first.
          if (irqPending && !in_isr && !advance) begin
            stateNext = DRAIN;
          end else if (allDone && !advance) begin
            advanceNext = 1'b1;
          end
        end
        DRAIN: begin
          if (allDone) begin
            flushNext    = 1'b1;
            epcNext      = pc_next;
            stateNext    = VECTOR;
            pendingClear = 1'b1;
          end
        end
        VECTOR: begin
          redirectValidNext = 1'b1;
          redirectAddrNext  = VEC_ADDR;
          inIsrNext         = 1'b1;
          stateNext         = RUN;
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      advance        <= 1'b0;
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_addr  <= '0;
      epc            <= '0;
      in_isr         <= 1'b0;
      running        <= 1'b0;
    end else begin
      state          <= stateNext;
      advance        <= advanceNext;
      flush          <= flushNext;
      redirect_valid <= redirectValidNext;
      redirect_addr  <= redirectAddrNext;
      epc            <= epcNext;
      in_isr         <= inIsrNext;
      running        <= (stateNext != IDLE);
    end
  end

`ifdef PIPE_SEQ_STALL_CNT_EN
  logic               stallClear, stallInc;
  logic [STALL_W-1:0] stallCount;

  assign stallClear = start && (state == IDLE);
  assign stallInc   = start && (state == RUN) && !advance;

  // Saturating count of RUN cycles without an advance; holds across stop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCount <= '0;
    end else if (stallClear) begin
      stallCount <= '0;
    end else if (stallInc && (stallCount != {STALL_W{1'b1}})) begin
      stallCount <= stallCount + 1'b1;
    end
  end

  assign stall_cnt = stallCount;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_sequencer.sv
// Scoreboard bench for pipe_sequencer: stimulus pushes expected strobes,
// a negedge monitor pops and compares them; directed checks cover timing.
module tb_pipe_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, start, irq, iret;
  logic [1:0] stage_done;
  logic [7:0] pc_next;
  logic       advance, flush, redirect_valid, running, in_isr;
  logic [7:0] redirect_addr, epc, stall_cnt;

  pipe_sequencer #(
    .NUM_STAGES (2),
    .ADDR_W     (8),
    .VEC_ADDR   (8'hF0),
    .STALL_W    (8)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .stage_done     (stage_done),
    .pc_next        (pc_next),
    .irq            (irq),
    .iret           (iret),
    .advance        (advance),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .epc            (epc),
    .running        (running),
    .in_isr         (in_isr),
    .stall_cnt      (stall_cnt)
  );

  always #5 clk = ~clk;

  localparam int EV_ADV = 0, EV_FLUSH = 1, EV_REDIR = 2;
  typedef struct {
    int         kind;
    logic [7:0] data;
  } evT;
  evT sbq[$];

  int passCnt = 0;
  int totalCnt = 0;
  int cyc = 0;
  int lastAdv = -100;

  always @(posedge clk) cyc++;

  function automatic logic [7:0] expStall(input int v);
`ifdef PIPE_SEQ_STALL_CNT_EN
    return (v > 255) ? 8'hFF : 8'(v);
`else
    return 8'h00;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push(input int kind, input logic [7:0] data);
    evT e;
    e.kind = kind;
    e.data = data;
    sbq.push_back(e);
  endtask

  task automatic pop(input int kind, input logic [7:0] data);
    evT e;
    if (sbq.size() == 0) begin
      totalCnt++;
      $display("FAIL unexpected_strobe: got kind %0d expected none (cycle %0d)", kind, cyc);
    end else begin
      e = sbq.pop_front();
      $display("txn cycle %0d kind %0d data %0h", cyc, kind, data);
      check("sb_kind", kind, e.kind);
      if (kind != EV_ADV) check("sb_data", data, e.data);
    end
  endtask

  // Monitor: every strobe the DUT presents must match the next expected event.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (advance) begin
        check("adv_gap", (cyc - lastAdv) >= 2, 1);
        lastAdv = cyc;
        pop(EV_ADV, 8'h00);
      end
      if (flush) pop(EV_FLUSH, epc);
      if (redirect_valid) pop(EV_REDIR, redirect_addr);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, "_advance"}, advance, 0);
    check({tag, "_flush"}, flush, 0);
    check({tag, "_redir"}, redirect_valid, 0);
    check({tag, "_raddr"}, redirect_addr, 0);
    check({tag, "_epc"}, epc, 0);
    check({tag, "_running"}, running, 0);
    check({tag, "_in_isr"}, in_isr, 0);
    check({tag, "_stall"}, stall_cnt, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; irq = 1'b0; iret = 1'b0;
    stage_done = 2'b00; pc_next = 8'h00;
    tick(); tick();
    checkAllZero("reset");
    rst_n = 1'b1;
    tick(); tick();
    check("idle_running", running, 0);

    // Phase 1: all stages done continuously -> advance every 2nd cycle.
    start = 1'b1; stage_done = 2'b11;
    repeat (5) push(EV_ADV, 8'h00);
    tick();
    check("run_running", running, 1);
    check("run_first_adv", advance, 0);
    for (int k = 2; k <= 11; k++) begin
      tick();
      check("adv_pattern", advance, (k % 2 == 0) ? 1 : 0);
    end
    stage_done = 2'b01;
    check("stall_after_10", stall_cnt, expStall(5));

    // Phase 2: stages never all done -> stall counter saturates, no advance.
    repeat (300) tick();
    check("stall_sat", stall_cnt, expStall(305));
    check("stall_no_adv", advance, 0);
    check("sb_empty_p2", sbq.size(), 0);

    // Phase 3: irq edge during an advance -> advance first, then drain/flush/vector.
    pc_next = 8'h23; stage_done = 2'b11;
    push(EV_ADV, 8'h00);
    tick();
    check("p3_adv", advance, 1);
    irq = 1'b1;
    tick();
    check("p3_adv_off", advance, 0);
    push(EV_FLUSH, 8'h23);
    push(EV_REDIR, 8'hF0);
    tick();
    check("p3_no_flush_yet", flush, 0);
    check("p3_no_adv_drain", advance, 0);
    tick();
    check("p3_flush", flush, 1);
    check("p3_epc", epc, 8'h23);
    stage_done = 2'b00;
    tick();
    check("p3_redir", redirect_valid, 1);
    check("p3_raddr", redirect_addr, 8'hF0);
    check("p3_in_isr", in_isr, 1);
    check("p3_flush_once", flush, 0);
    tick();
    check("p3_redir_once", redirect_valid, 0);

    // Phase 4: second irq masked while in_isr; iret releases it.
    irq = 1'b0; tick();
    irq = 1'b1; tick();
    stage_done = 2'b11;
    push(EV_ADV, 8'h00);
    tick();
    check("p4_masked_adv", advance, 1);
    stage_done = 2'b00;
    tick();
    iret = 1'b1;
    tick();
    iret = 1'b0;
    check("p4_iret_clr", in_isr, 0);
    pc_next = 8'h47; stage_done = 2'b11;
    push(EV_FLUSH, 8'h47);
    push(EV_REDIR, 8'hF0);
    tick();
    check("p4_drain_no_adv", advance, 0);
    check("p4_drain_no_flush", flush, 0);
    tick();
    check("p4_flush", flush, 1);
    stage_done = 2'b00;
    tick();
    check("p4_redir", redirect_valid, 1);
    check("p4_in_isr", in_isr, 1);
    check("p4_epc", epc, 8'h47);

    // Phase 5: stop while draining, irq edge in IDLE ignored, restart.
    iret = 1'b1; tick(); iret = 1'b0;
    irq = 1'b0; tick();
    irq = 1'b1; tick();
    tick();
    start = 1'b0;
    tick();
    check("stop_running", running, 0);
    check("stop_in_isr", in_isr, 0);
    check("stop_flush", flush, 0);
    check("stop_adv", advance, 0);
    check("stop_redir", redirect_valid, 0);
    check("stop_epc_hold", epc, 8'h47);
    check("stop_stall_hold", stall_cnt, expStall(305));
    irq = 1'b0; tick();
    irq = 1'b1; tick();
    tick();
    start = 1'b1; stage_done = 2'b00;
    tick();
    check("restart_running", running, 1);
    check("restart_stall_clr", stall_cnt, 0);
    stage_done = 2'b11;
    push(EV_ADV, 8'h00);
    tick();
    check("restart_adv", advance, 1);
    check("restart_stall", stall_cnt, expStall(1));
    stage_done = 2'b00;
    tick();

    // Phase 6: asynchronous reset mid-RUN.
    #2 rst_n = 1'b0;
    #1;
    checkAllZero("async_rst");
    start = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_running", running, 0);
    check("post_rst_adv", advance, 0);
    check("sb_empty_end", sbq.size(), 0);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

// File: doc/pipe_sequencer.md
# pipe_sequencer

Parametrised pipeline sequencer for the accumulator processor. It generalises the fixed two-stage "all stages complete → advance" handshake to NUM_STAGES stages, and adds start/stop control, interrupt capture with drain-and-flush, vectoring with return-PC save, and stall accounting. It sits between the fetch/decode/execute stages and the top level, and drives their common advance strobe and PC redirect.

## Interface
- NUM_STAGES, 2: number of pipeline stages handshaking via `stage_done`.
- ADDR_W, 8: PC/address width.
- VEC_ADDR, 8'hF0: interrupt vector address, ADDR_W bits.
- STALL_W, 8: stall counter width.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  level; high = run (StartEverything equivalent).
- stage_done  in  NUM_STAGES  per-stage completion flags.
- pc_next  in  ADDR_W  next PC from the execute stage; saved on interrupt entry.
- irq  in  1  external interrupt request, level.
- iret  in  1  one-cycle pulse from execute on return-from-interrupt.
- advance  out  1  one-cycle strobe: all stages load their next contents.
- flush  out  1  one-cycle strobe: all stages discard their contents.
- redirect_valid  out  1  one-cycle strobe: fetch loads `redirect_addr`.
- redirect_addr  out  ADDR_W  redirect target.
- epc  out  ADDR_W  saved return PC.
- running  out  1  high in RUN, DRAIN or VECTOR.
- in_isr  out  1  interrupt service active; further interrupts masked.
- stall_cnt  out  STALL_W  saturating count of RUN cycles without advance.

## Operation
- States: IDLE, RUN, DRAIN, VECTOR.
- Reset: state IDLE. `advance`, `flush`, `redirect_valid`, `in_isr` and internal `irq_pending` = 0. `redirect_addr`, `epc` and `stall_cnt` = 0. `running` = 0.
- IDLE → RUN when `start` = 1. Entering RUN clears `stall_cnt`. `irq` edges are ignored in IDLE.
- RUN
  - If `&stage_done` and `advance` = 0: `advance` = 1 next cycle. Otherwise `advance` = 0.
  - `stage_done` is not acted on in the cycle `advance` is high; stages clear their flags on `advance`.
  - Each RUN cycle without `advance` increments `stall_cnt`, saturating at all-ones.
- Interrupt capture
  - A rising edge of `irq` (registered previous sample) sets `irq_pending` in any non-IDLE state.
  - `irq_pending` is cleared on VECTOR entry.
- RUN → DRAIN when `irq_pending` = 1, `in_isr` = 0 and `advance` = 0.
- DRAIN
  - No `advance` is issued.
  - When `&stage_done`: `flush` = 1 for one cycle, `epc` ← `pc_next`, → VECTOR.
- VECTOR (one cycle)
  - `redirect_valid` = 1, `redirect_addr` = VEC_ADDR, `in_isr` ← 1.
  - Then → RUN.
- `iret` pulse clears `in_isr`. `redirect_valid` is not issued; execute supplies `epc` through `pc_next`.
- Stop: `start` = 0 in any state → IDLE next cycle. All strobes drop, `irq_pending` and `in_isr` clear, `epc` and `stall_cnt` hold.
- Simultaneous events
  - Irq edge in the same cycle as all-done: `advance` issues first; DRAIN follows next cycle.
  - `iret` with `irq_pending` = 1: `in_isr` clears; DRAIN entered the following cycle.
  - `start` = 0 overrides everything.

## Timing
- Advance latency: all-done sampled at edge N → `advance` high during cycle N+1.
- Minimum advance period is 2 cycles.
- Interrupt latency, with stages already done: edge sampled at N → `irq_pending` at N+1 → DRAIN at N+2 → `flush` at N+3 → `redirect_valid` at N+4.
- All outputs are registered; no combinational input-to-output path.

## Configuration
- PIPE_SEQ_STALL_CNT_EN
  - Defined: stall counter implemented as described.
  - Undefined: counter logic removed and `stall_cnt` tied to 0; all other behaviour identical.

## Structure
- `pipe_seq_pkg` holds:
  - the state enum (IDLE, RUN, DRAIN, VECTOR);
  - the default vector constant;
  - the default widths.
- One sub-module, `irq_capture`: edge detect plus pending latch, with set (edge while enabled) and clear (VECTOR entry or stop).

## Test plan
- Reset then `start` = 1, NUM_STAGES = 2, `stage_done` = 2'b11 for 10 cycles → `advance` pulses every 2nd cycle; `stall_cnt` = 5.
- `stage_done` = 2'b01 held 300 cycles with STALL_W = 8 → `stall_cnt` saturates at 255; no `advance`.
- `pc_next` = 8'h23, irq edge while stages done → DRAIN, `flush` one cycle, `epc` = 8'h23, `redirect_valid` with `redirect_addr` = 8'hF0, `in_isr` = 1.
- Second irq edge while `in_isr` = 1 → no DRAIN; `iret` pulse → DRAIN next cycle, second vectoring occurs.
- Irq edge coincident with all-done → `advance` pulse first, then DRAIN next cycle.
- `start` dropped in DRAIN, then `rst_n` asserted mid-RUN → IDLE with all strobes 0; after reset, every output = 0.
